pad_core_bridge: RTL and testbench

Registered boundary stage between the pad ring and chip_core, placed between the pad-cell Y/A/OE signals and the core ports. It performs five functions:
- Conditions the raw pad reset: asynchronous assert, synchronised and stretched deassert.
- Synchronises all pad inputs into the clock domain.
- Glitch-filters ena.
- Registers all core-to-pad outputs.
- Holds outputs safe during reset and while ena is low.

---
 rtl/pad_core_bridge.sv | 172 +++++++++++++++++
 tb/tb_pad_core_bridge.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pad_core_bridge.sv
// Registered boundary between the pad ring and chip_core: reset conditioning,
// input synchronisation, ena glitch filtering and registered, safe-held outputs.
module pad_core_bridge #(
  parameter int         SYNC_STAGES = 2,
  parameter int         RST_STRETCH = 4,
  parameter int         ENA_FILT    = 8,
  parameter logic [7:0] UO_RESET    = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena_pad,
  input  logic [7:0] ui_pad,
  input  logic [7:0] uio_in_pad,
  output logic [7:0] ui_sync,
  output logic [7:0] uio_sync,
  output logic       ena_filt,
  output logic       rst_n_core,
  input  logic [7:0] uo_core,
  input  logic [7:0] uio_out_core,
  input  logic [7:0] uio_oe_core,
  output logic [7:0] uo_pad,
  output logic [7:0] uio_out_pad,
  output logic [7:0] uio_oe_pad
);

  localparam logic [7:0] RST_LAST = 8'(RST_STRETCH - 1);
  localparam logic [7:0] ENA_LAST = 8'(ENA_FILT - 1);

  typedef enum logic [1:0] {ST_SYNC, ST_HOLD, ST_RUN} rst_state_e;

  rst_state_e             state_q, state_d;
  logic [SYNC_STAGES-1:0] rst_chain_q, rst_chain_d;
  logic [7:0]             hold_cnt_q, hold_cnt_d;
  logic                   rst_n_core_q, rst_n_core_d;

  logic [7:0]             ui_chain_q [SYNC_STAGES];
  logic [7:0]             ui_chain_d [SYNC_STAGES];
  logic [7:0]             uio_meta_q [SYNC_STAGES-1];
  logic [7:0]             uio_meta_d [SYNC_STAGES-1];
  logic [7:0]             uio_sync_q, uio_sync_d;

  logic [SYNC_STAGES-1:0] ena_chain_q, ena_chain_d;
  logic                   ena_s;
  logic                   ena_filt_q, ena_filt_d;
  logic [7:0]             ena_cnt_q, ena_cnt_d;

  logic [7:0]             uo_pad_q, uo_pad_d;
  logic [7:0]             uio_out_pad_q, uio_out_pad_d;
  logic [7:0]             uio_oe_pad_q, uio_oe_pad_d;

  assign ena_s = ena_chain_q[SYNC_STAGES-1];

  // Synchroniser chains; uio is masked at its last stage so driven bits read 0.
  always_comb begin
    rst_chain_d = {rst_chain_q[SYNC_STAGES-2:0], 1'b1};
    ena_chain_d = {ena_chain_q[SYNC_STAGES-2:0], ena_pad};
    ui_chain_d[0] = ui_pad;
    for (int i = 1; i < SYNC_STAGES; i++) ui_chain_d[i] = ui_chain_q[i-1];
    uio_meta_d[0] = uio_in_pad;
    for (int i = 1; i < SYNC_STAGES - 1; i++) uio_meta_d[i] = uio_meta_q[i-1];
    uio_sync_d = uio_meta_q[SYNC_STAGES-2] & ~uio_oe_pad_q;
  end

  // The chain output is seen one edge after it rises, so HOLD starts its count at 1.
  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    rst_n_core_d = rst_n_core_q;
    case (state_q)
      ST_SYNC: begin
        if (rst_chain_q[SYNC_STAGES-1]) begin
          if (RST_LAST == 8'd0) begin
            state_d      = ST_RUN;
            rst_n_core_d = 1'b1;
          end else begin
            state_d    = ST_HOLD;
            hold_cnt_d = 8'd1;
          end
        end
      end
      ST_HOLD: begin
        if (hold_cnt_q == RST_LAST) begin
          state_d      = ST_RUN;
          rst_n_core_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      ST_RUN: ;
      default: begin
        state_d      = ST_SYNC;
        hold_cnt_d   = 8'd0;
        rst_n_core_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    ena_filt_d = ena_filt_q;
    ena_cnt_d  = ena_cnt_q;
    if (!rst_n_core_q) begin
      ena_filt_d = 1'b0;
      ena_cnt_d  = 8'd0;
    end else if (ena_s == ena_filt_q) begin
      ena_cnt_d = 8'd0;
    end else if (ena_cnt_q == ENA_LAST) begin
      ena_filt_d = ena_s;
      ena_cnt_d  = 8'd0;
    end else begin
      ena_cnt_d = ena_cnt_q + 8'd1;
    end
  end

  // Reset forces safe values; a low ena freezes data and tristates all uio.
  always_comb begin
    uo_pad_d      = uo_pad_q;
    uio_out_pad_d = uio_out_pad_q;
    uio_oe_pad_d  = uio_oe_pad_q;
    if (!rst_n_core_q) begin
      uo_pad_d      = UO_RESET;
      uio_out_pad_d = 8'h00;
      uio_oe_pad_d  = 8'h00;
    end else if (!ena_filt_q) begin
      uio_oe_pad_d  = 8'h00;
    end else begin
      uo_pad_d      = uo_core;
      uio_out_pad_d = uio_out_core;
      uio_oe_pad_d  = uio_oe_core;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_SYNC;
      rst_chain_q   <= '0;
      hold_cnt_q    <= 8'd0;
      rst_n_core_q  <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) ui_chain_q[i] <= 8'h00;
      for (int i = 0; i < SYNC_STAGES - 1; i++) uio_meta_q[i] <= 8'h00;
      uio_sync_q    <= 8'h00;
      ena_chain_q   <= '0;
      ena_filt_q    <= 1'b0;
      ena_cnt_q     <= 8'd0;
      uo_pad_q      <= UO_RESET;
      uio_out_pad_q <= 8'h00;
      uio_oe_pad_q  <= 8'h00;
    end else begin
      state_q       <= state_d;
      rst_chain_q   <= rst_chain_d;
      hold_cnt_q    <= hold_cnt_d;
      rst_n_core_q  <= rst_n_core_d;
      for (int i = 0; i < SYNC_STAGES; i++) ui_chain_q[i] <= ui_chain_d[i];
      for (int i = 0; i < SYNC_STAGES - 1; i++) uio_meta_q[i] <= uio_meta_d[i];
      uio_sync_q    <= uio_sync_d;
      ena_chain_q   <= ena_chain_d;
      ena_filt_q    <= ena_filt_d;
      ena_cnt_q     <= ena_cnt_d;
      uo_pad_q      <= uo_pad_d;
      uio_out_pad_q <= uio_out_pad_d;
      uio_oe_pad_q  <= uio_oe_pad_d;
    end
  end

  assign ui_sync     = ui_chain_q[SYNC_STAGES-1];
  assign uio_sync    = uio_sync_q;
  assign ena_filt    = ena_filt_q;
  assign rst_n_core  = rst_n_core_q;
  assign uo_pad      = uo_pad_q;
  assign uio_out_pad = uio_out_pad_q;
  assign uio_oe_pad  = uio_oe_pad_q;

endmodule

// File: tb/tb_pad_core_bridge.sv
// Bench for pad_core_bridge: directed scenarios plus randomized traffic
// compared against an edge-counting behavioural model.
module tb_pad_core_bridge;

  localparam int         S   = 2;
  localparam int         R   = 4;
  localparam int         EF  = 8;
  localparam logic [7:0] UOR = 8'h00;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena_pad = 1'b0;
  logic [7:0] ui_pad = 8'h00, uio_in_pad = 8'h00;
  logic [7:0] uo_core = 8'h00, uio_out_core = 8'h00, uio_oe_core = 8'h00;
  logic [7:0] ui_sync, uio_sync, uo_pad, uio_out_pad, uio_oe_pad;
  logic       ena_filt, rst_n_core;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pad_core_bridge #(
    .SYNC_STAGES(S), .RST_STRETCH(R), .ENA_FILT(EF), .UO_RESET(UOR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena_pad(ena_pad), .ui_pad(ui_pad),
    .uio_in_pad(uio_in_pad), .ui_sync(ui_sync), .uio_sync(uio_sync),
    .ena_filt(ena_filt), .rst_n_core(rst_n_core), .uo_core(uo_core),
    .uio_out_core(uio_out_core), .uio_oe_core(uio_oe_core), .uo_pad(uo_pad),
    .uio_out_pad(uio_out_pad), .uio_oe_pad(uio_oe_pad)
  );

  // Behavioural model: pad samples delayed through queues, reset release by
  // counting edges, ena decided by a run of consecutive disagreeing samples.
  logic [7:0] ui_q[$], uio_q[$];
  logic       ena_q[$];
  int         m_since = 0, m_run = 0;
  logic       m_rstc = 1'b0, m_filt = 1'b0, m_ena_s = 1'b0, t1;
  logic [7:0] m_ui_sync = 8'h00, m_uio_sync = 8'h00, t8;
  logic [7:0] m_uo = UOR, m_uio_out = 8'h00, m_oe = 8'h00;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_since = 0; m_run = 0; m_rstc = 1'b0; m_filt = 1'b0; m_ena_s = 1'b0;
      m_ui_sync = 8'h00; m_uio_sync = 8'h00;
      m_uo = UOR; m_uio_out = 8'h00; m_oe = 8'h00;
      ui_q.delete(); uio_q.delete(); ena_q.delete();
      for (int i = 0; i < S - 1; i++) begin
        ui_q.push_back(8'h00); uio_q.push_back(8'h00); ena_q.push_back(1'b0);
      end
    end else begin
      t8 = uio_q.pop_front(); uio_q.push_back(uio_in_pad);
      m_uio_sync = t8 & ~m_oe;
      t8 = ui_q.pop_front(); ui_q.push_back(ui_pad);
      m_ui_sync = t8;
      if (!m_rstc) begin
        m_uo = UOR; m_uio_out = 8'h00; m_oe = 8'h00;
      end else if (!m_filt) begin
        m_oe = 8'h00;
      end else begin
        m_uo = uo_core; m_uio_out = uio_out_core; m_oe = uio_oe_core;
      end
      if (!m_rstc) begin
        m_filt = 1'b0; m_run = 0;
      end else if (m_ena_s != m_filt) begin
        m_run = m_run + 1;
        if (m_run == EF) begin m_filt = m_ena_s; m_run = 0; end
      end else begin
        m_run = 0;
      end
      t1 = ena_q.pop_front(); ena_q.push_back(ena_pad);
      m_ena_s = t1;
      m_since = m_since + 1;
      m_rstc = (m_since >= S + R);
    end
  end

  task automatic test_reset();
    logic exp;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (rst_n_core !== 1'b0 || ena_filt !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_ctrl: rst_n_core=%b ena_filt=%b, required 0 0", rst_n_core, ena_filt);
    end
    n_checks++;
    if (uo_pad !== UOR || uio_out_pad !== 8'h00 || uio_oe_pad !== 8'h00) begin
      n_errors++;
      $display("FAIL reset_outs: uo=%h uio_out=%h oe=%h, required %h 00 00", uo_pad, uio_out_pad, uio_oe_pad, UOR);
    end
    n_checks++;
    if (ui_sync !== 8'h00 || uio_sync !== 8'h00) begin
      n_errors++;
      $display("FAIL reset_sync: ui_sync=%h uio_sync=%h, required 00 00", ui_sync, uio_sync);
    end
    #2 rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      exp = (k >= S + R);
      n_checks++;
      if (rst_n_core !== exp) begin
        n_errors++;
        $display("FAIL rst_release edge %0d: rst_n_core=%b, required %b", k, rst_n_core, exp);
      end
      n_checks++;
      if (uo_pad !== UOR || uio_oe_pad !== 8'h00) begin
        n_errors++;
        $display("FAIL rst_safe edge %0d: uo=%h oe=%h, required %h 00", k, uo_pad, uio_oe_pad, UOR);
      end
    end
  endtask

  task automatic test_ena_filter();
    logic exp;
    @(negedge clk); ena_pad = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      exp = (k >= S + EF);
      n_checks++;
      if (ena_filt !== exp) begin
        n_errors++;
        $display("FAIL ena_rise edge %0d: ena_filt=%b, required %b", k, ena_filt, exp);
      end
    end
    @(negedge clk); ena_pad = 1'b0;
    repeat (5) @(negedge clk);
    ena_pad = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (ena_filt !== 1'b1) begin
        n_errors++;
        $display("FAIL ena_glitch edge %0d: ena_filt=%b, required 1", k, ena_filt);
      end
    end
  endtask

  task automatic test_output_reg();
    @(negedge clk);
    uo_core = 8'hA5; uio_oe_core = 8'h0F; uio_out_core = 8'h3C;
    #1;
    n_checks++;
    if (uo_pad !== 8'h00) begin
      n_errors++;
      $display("FAIL out_latency: uo_pad=%h before edge, required 00", uo_pad);
    end
    @(posedge clk); #1;
    n_checks++;
    if (uo_pad !== 8'hA5 || uio_oe_pad !== 8'h0F || uio_out_pad !== 8'h3C) begin
      n_errors++;
      $display("FAIL out_load: uo=%h oe=%h uio_out=%h, required a5 0f 3c", uo_pad, uio_oe_pad, uio_out_pad);
    end
  endtask

  task automatic test_sync();
    @(negedge clk); uio_in_pad = 8'hFF; ui_pad = 8'h5A;
    @(posedge clk); #1;
    n_checks++;
    if (ui_sync !== 8'h00 || uio_sync !== 8'h00) begin
      n_errors++;
      $display("FAIL sync_edge1: ui_sync=%h uio_sync=%h, required 00 00", ui_sync, uio_sync);
    end
    @(posedge clk); #1;
    n_checks++;
    if (ui_sync !== 8'h5A) begin
      n_errors++;
      $display("FAIL ui_sync_edge2: ui_sync=%h, required 5a", ui_sync);
    end
    n_checks++;
    if (uio_sync !== 8'hF0) begin
      n_errors++;
      $display("FAIL uio_mask: uio_sync=%h, required f0", uio_sync);
    end
  endtask

  task automatic test_ena_drop();
    int fall_edge;
    fall_edge = 0;
    @(negedge clk); ena_pad = 1'b0;
    for (int k = 1; k <= 30 && fall_edge == 0; k++) begin
      @(posedge clk); #1;
      if (ena_filt === 1'b0) fall_edge = k;
    end
    n_checks++;
    if (fall_edge != S + EF) begin
      n_errors++;
      $display("FAIL ena_fall: fell at edge %0d, required %0d", fall_edge, S + EF);
    end
    n_checks++;
    if (uio_oe_pad !== 8'h0F) begin
      n_errors++;
      $display("FAIL ena_fall_next: oe=%h on falling edge, required 0f", uio_oe_pad);
    end
    @(negedge clk); uo_core = 8'h11;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (uo_pad !== 8'hA5 || uio_oe_pad !== 8'h00 || uio_out_pad !== 8'h3C) begin
        n_errors++;
        $display("FAIL ena_low_hold %0d: uo=%h oe=%h uio_out=%h, required a5 00 3c", k, uo_pad, uio_oe_pad, uio_out_pad);
      end
    end
  endtask

  task automatic test_async_reset();
    int waited;
    waited = 0;
    @(negedge clk); ena_pad = 1'b1; uo_core = 8'hA5;
    while (ena_filt !== 1'b1 && waited < 30) begin
      @(posedge clk); #1; waited++;
    end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (ena_filt !== 1'b1 || uo_pad !== 8'hA5) begin
      n_errors++;
      $display("FAIL async_pre: ena_filt=%b uo=%h, required 1 a5", ena_filt, uo_pad);
    end
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (uo_pad !== UOR || uio_oe_pad !== 8'h00 || ena_filt !== 1'b0 || rst_n_core !== 1'b0) begin
      n_errors++;
      $display("FAIL async_assert: uo=%h oe=%h ena_filt=%b rst_n_core=%b, required %h 00 0 0",
               uo_pad, uio_oe_pad, ena_filt, rst_n_core, UOR);
    end
    test_reset();
  endtask

  task automatic test_random();
    int hold;
    logic [41:0] got, exp;
    hold = 3;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      ui_pad = 8'($urandom); uio_in_pad = 8'($urandom);
      uo_core = 8'($urandom); uio_out_core = 8'($urandom); uio_oe_core = 8'($urandom);
      if (hold == 0) begin
        ena_pad = ~ena_pad;
        hold = $urandom_range(1, 20);
      end
      hold--;
      if (i == 250) #2 rst_n = 1'b0;
      if (i == 254) #2 rst_n = 1'b1;
      @(posedge clk); #1;
      got = {rst_n_core, ena_filt, ui_sync, uio_sync, uo_pad, uio_out_pad, uio_oe_pad};
      exp = {m_rstc, m_filt, m_ui_sync, m_uio_sync, m_uo, m_uio_out, m_oe};
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL random cycle %0d: {rstc,filt,ui,uio,uo,uio_out,oe}=%h, required %h", i, got, exp);
      end
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    test_reset();
    test_ena_filter();
    test_output_reg();
    test_sync();
    test_ena_drop();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
